// File: rtl/apb_slave_bank.sv
// APB target holding three independent register banks (one per Pselx bit)
// with a protocol-tracking FSM that reports the first sequencing violation.
module apb_slave_bank #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        prot_err,
  output logic [2:0]  err_code,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [2:0] ERR_MULTI      = 3'd1;
  localparam logic [2:0] ERR_EN_IDLE    = 3'd2;
  localparam logic [2:0] ERR_NO_ENABLE  = 3'd3;
  localparam logic [2:0] ERR_FIELD      = 3'd4;
  localparam logic [2:0] ERR_EN_HELD    = 3'd5;

  state_t state_reg, state_next;

  logic [2:0]  sel_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        write_reg;

  logic [31:0] prdata_reg;
  logic        prot_err_reg;
  logic [2:0]  err_code_reg;

  logic        sel;
  logic        multi;
  logic        match;
  logic        setup_go;
  logic        commit;
  logic        viol;
  logic [2:0]  code;

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [2:0][31:0]  rd_bank;
  logic [31:0]       rd_mux;

  assign sel    = |Pselx;
  assign multi  = sel && ((Pselx & (Pselx - 3'd1)) != 3'd0);
  assign match  = (Pselx == sel_reg) && (Paddr == addr_reg) &&
                  (Pwrite == write_reg) && (Pwdata == wdata_reg);
  assign rd_idx = Paddr[IDX_W+1:2];
  assign wr_idx = addr_reg[IDX_W+1:2];

  // Next-state, violation detection and strobes. A multi-select overrides
  // every state, which also gives it the highest error priority.
  always_comb begin
    state_next = state_reg;
    setup_go   = 1'b0;
    commit     = 1'b0;
    viol       = 1'b0;
    code       = 3'd0;
    if (multi) begin
      viol       = 1'b1;
      code       = ERR_MULTI;
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sel && !Penable) begin
            state_next = SETUP;
            setup_go   = 1'b1;
          end else if (sel && Penable) begin
            viol = 1'b1;
            code = ERR_EN_IDLE;
          end
        end
        SETUP: begin
          if (!Penable) begin
            // Missing enable: flag it, then treat this cycle as if idle,
            // so a fresh select still starts a new setup.
            viol = 1'b1;
            code = match ? ERR_NO_ENABLE : ERR_FIELD;
            if (sel) begin
              state_next = SETUP;
              setup_go   = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else if (!match) begin
            viol       = 1'b1;
            code       = ERR_FIELD;
            state_next = IDLE;
          end else begin
            state_next = ACCESS;
            commit     = write_reg;
          end
        end
        ACCESS: begin
          if (Penable) begin
            viol       = 1'b1;
            code       = ERR_EN_HELD;
            state_next = IDLE;
          end else if (sel) begin
            state_next = SETUP;
            setup_go   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < 3; i++) begin
      if (Pselx[i]) rd_mux = rd_mux | rd_bank[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_bank
      logic [31:0] mem [DEPTH];

      always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit && sel_reg[gi]) begin
          mem[wr_idx] <= wdata_reg;
        end
      end

      assign rd_bank[gi] = mem[rd_idx];
    end
  endgenerate

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      write_reg    <= 1'b0;
      prdata_reg   <= '0;
      prot_err_reg <= 1'b0;
      err_code_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (setup_go) begin
        sel_reg   <= Pselx;
        addr_reg  <= Paddr;
        wdata_reg <= Pwdata;
        write_reg <= Pwrite;
        if (!Pwrite) prdata_reg <= rd_mux;
      end
      // First error wins, except that a clear on the same edge lets a new one in.
      if (viol && (!prot_err_reg || err_clr)) begin
        prot_err_reg <= 1'b1;
        err_code_reg <= code;
      end else if (err_clr) begin
        prot_err_reg <= 1'b0;
        err_code_reg <= '0;
      end
    end
  end

  assign Prdata   = prdata_reg;
  assign prot_err = prot_err_reg;
  assign err_code = err_code_reg;

endmodule

// File: doc/apb_slave_bank.md
Name: apb_slave_bank

Overview:
- Downstream APB target of the AHB-to-APB bridge.
- Consumes Pselx/Penable/Pwrite/Paddr/Pwdata and returns Prdata, which the bridge forwards as Hrdata during the enable cycle.
- Implements three independent register banks, one per Pselx bit (0x8000_0000, 0x8400_0000 and 0x8800_0000 windows).
- Runs a protocol-tracking FSM that flags APB sequencing violations with a sticky error code.

Parameters:
- DEPTH, 16: 32-bit words per bank; power of two, 2..256.
- IDX_W, $clog2(DEPTH): word index width; index = Paddr[IDX_W+1:2].

Ports:
- Hclk  in  1  clock; all state updates on rising edge.
- Hresetn  in  1  reset; synchronous, active-low.
- Pselx  in  3  one-hot bank select from bridge.
- Penable  in  1  APB enable (access phase).
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  32  byte address; only bits [IDX_W+1:2] used; [1:0] ignored.
- Pwdata  in  32  write data.
- Prdata  out  32  read data, registered.
- prot_err  out  1  sticky protocol-violation flag.
- err_code  out  3  code of first violation since last clear.
- err_clr  in  1  clears prot_err/err_code.

Behaviour:
- Reset (Hresetn = 0 at a rising edge): all bank words = 0, Prdata = 0, FSM = IDLE, prot_err = 0, err_code = 0.
- Reset mid-transfer aborts the transfer; no write commits on the reset edge.
- sel = Pselx != 0. multi = Pselx not one-hot and not zero.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: sel & !Penable & !multi -> SETUP. sel & Penable -> error 2, stay IDLE. Otherwise stay.
  - SETUP: captures Pselx, Paddr, Pwrite, Pwdata. Next cycle must show Penable = 1 with identical captured fields -> ACCESS.
  - SETUP, Penable = 0 next cycle -> error 3; re-evaluate as IDLE.
  - SETUP, any captured field differs -> error 4 -> IDLE.
  - ACCESS (one cycle): sel & !Penable -> SETUP (back-to-back allowed, no idle cycle). !sel -> IDLE. Penable = 1 -> error 5 -> IDLE.
- multi in any state -> error 1; FSM -> IDLE; no write; Prdata unchanged.
- Write commit: on the rising edge where FSM = SETUP, Penable = 1, Pwrite = 1 and no violation is detected, set bank[sel][idx] <= Pwdata. Exactly one write per transfer.
- Read: on the rising edge where IDLE/ACCESS -> SETUP with Pwrite = 0, set Prdata <= bank[sel][idx].
  - Prdata is therefore valid for the whole access cycle (Penable = 1) and holds until the next read setup.
  - Writes never change Prdata.
- Read of a word written in the immediately preceding transfer returns the new value (the write committed one or more edges earlier).
- Error priority when several violations occur in one cycle: 1 > 2 > 4 > 5 > 3.
- err_code latches only when prot_err = 0 (first error wins); prot_err is set on the same edge.
- err_clr = 1 clears both outputs next edge. A new violation on the same edge as err_clr wins: flag stays set with the new code.
- Index beyond DEPTH is impossible by construction: the index is truncated to IDX_W bits, so addresses wrap modulo DEPTH within a bank.
- No wait states; the bridge has no Pready. Every legal transfer is exactly 2 cycles.

Test Plan:
- Reset then read bank0 word 3 (Pselx = 001, Paddr = 0x8000_000C, setup + enable) -> Prdata = 0x0000_0000 in enable cycle; prot_err = 0.
- Write 0xDEAD_BEEF to bank1 word 5 (Pselx = 010, Paddr = 0x8400_0014), then read the same address back-to-back -> Prdata = 0xDEAD_BEEF during read enable. Read bank0 word 5 -> 0.
- DEPTH = 16: write 0x1234_5678 to Paddr = 0x8800_0040 (idx 16 wraps to 0) -> a read at 0x8800_0000 returns 0x1234_5678.
- Penable = 1 with Pselx = 100 from IDLE -> prot_err = 1, err_code = 2, no write. Then Pselx = 011 -> err_code stays 2.
- Setup write to 0x8000_0008; in enable cycle Paddr changes to 0x8000_000C -> err_code = 4; neither word written.
- Assert err_clr while a new Penable-held-2-cycles violation occurs -> prot_err = 1, err_code = 5. err_clr alone next cycle -> prot_err = 0, err_code = 0.
